instn_encode: RTL and testbench

Pipelined RV32I instruction encoder: the inverse of the ID-stage decode. It accepts decoded fields (format, opcode, funct3, funct7, register addresses, full 32-bit immediate) over a valid/ready handshake and emits the packed 32-bit instruction word two cycles later. It feeds the self-test program loader and the instruction-memory write path, with full backpressure and in-order delivery.

---
 rtl/instn_encode.sv | 125 ++++++++++++
 tb/tb_instn_encode.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instn_encode.sv
// Two-stage RV32I instruction encoder: decoded fields in, packed 32-bit word out.
// Optional immediate/format range checking is built when INSTN_ENCODE_RANGECHK_EN is defined.
module instn_encode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmtI,
  input  logic [6:0]  opI,
  input  logic [2:0]  funct3I,
  input  logic [6:0]  funct7I,
  input  logic [4:0]  rsI,
  input  logic [4:0]  rtI,
  input  logic [4:0]  rdI,
  input  logic [31:0] immI,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instnO,
  output logic        errO,
  output logic [15:0] emit_count
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        s1_valid;
  logic [2:0]  s1_fmt;
  logic [6:0]  s1_op;
  logic [2:0]  s1_f3;
  logic [6:0]  s1_f7;
  logic [4:0]  s1_rs;
  logic [4:0]  s1_rt;
  logic [4:0]  s1_rd;
  logic [31:0] s1_imm;

  logic        s2_advance;
  logic [31:0] enc_word;
  logic        enc_err;

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer's ready never looks at its own valid, so in_ready depends only on
  // registered occupancy and out_ready.
  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;

  always_comb begin
    enc_word = NOP;
    case (s1_fmt)
      FMT_R: enc_word = {s1_f7, s1_rt, s1_rs, s1_f3, s1_rd, s1_op};
      FMT_I: enc_word = {s1_imm[11:0], s1_rs, s1_f3, s1_rd, s1_op};
      FMT_S: enc_word = {s1_imm[11:5], s1_rt, s1_rs, s1_f3, s1_imm[4:0], s1_op};
      FMT_B: enc_word = {s1_imm[12], s1_imm[10:5], s1_rt, s1_rs, s1_f3,
                         s1_imm[4:1], s1_imm[11], s1_op};
      FMT_U: enc_word = {s1_imm[31:12], s1_rd, s1_op};
      FMT_J: enc_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                         s1_rd, s1_op};
      default: enc_word = NOP;
    endcase
  end

`ifdef INSTN_ENCODE_RANGECHK_EN
  // Flag immediates that do not survive truncation to the format's field.
  always_comb begin
    enc_err = 1'b0;
    case (s1_fmt)
      FMT_R:        enc_err = 1'b0;
      FMT_I, FMT_S: enc_err = (s1_imm[31:11] != {21{s1_imm[11]}});
      FMT_B:        enc_err = (s1_imm[31:12] != {20{s1_imm[12]}}) || s1_imm[0];
      FMT_U:        enc_err = (s1_imm[11:0] != 12'd0);
      FMT_J:        enc_err = (s1_imm[31:20] != {12{s1_imm[20]}}) || s1_imm[0];
      default:      enc_err = 1'b1;
    endcase
  end
`else
  assign enc_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_fmt     <= '0;
      s1_op      <= '0;
      s1_f3      <= '0;
      s1_f7      <= '0;
      s1_rs      <= '0;
      s1_rt      <= '0;
      s1_rd      <= '0;
      s1_imm     <= '0;
      out_valid  <= 1'b0;
      instnO     <= '0;
      errO       <= 1'b0;
      emit_count <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_fmt <= fmtI;
          s1_op  <= opI;
          s1_f3  <= funct3I;
          s1_f7  <= funct7I;
          s1_rs  <= rsI;
          s1_rt  <= rtI;
          s1_rd  <= rdI;
          s1_imm <= immI;
        end
      end
      // The word register only reloads with real data, so it holds while empty.
      if (s2_advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          instnO <= enc_word;
          errO   <= enc_err;
        end
      end
      if (out_valid && out_ready)
        emit_count <= emit_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_instn_encode.sv
// Bench for instn_encode: directed vector table, backpressure/reset/wrap sequences
// and randomized traffic checked against an arithmetic reference model.
module tb_instn_encode;

`ifdef INSTN_ENCODE_RANGECHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmtI;
  logic [6:0]  opI;
  logic [2:0]  funct3I;
  logic [6:0]  funct7I;
  logic [4:0]  rsI;
  logic [4:0]  rtI;
  logic [4:0]  rdI;
  logic [31:0] immI;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instnO;
  logic        errO;
  logic [15:0] emit_count;

  instn_encode dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmtI(fmtI), .opI(opI), .funct3I(funct3I), .funct7I(funct7I),
    .rsI(rsI), .rtI(rtI), .rdI(rdI), .immI(immI),
    .out_valid(out_valid), .out_ready(out_ready), .instnO(instnO),
    .errO(errO), .emit_count(emit_count)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
  } bun_t;

  typedef struct {
    bun_t        b;
    logic [31:0] exp_w;
    logic        exp_err_chk;
  } vec_t;

  int vectors    = 0;
  int miscompares = 0;
  int model_emit = 0;
  logic last_acc;
  logic [32:0] exp_q[$];

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    logic [31:0] mask;
    mask = (32'h1 << (hi - lo + 1)) - 32'h1;
    return (v >> lo) & mask;
  endfunction

  // Reference: {err, word} from the format rules using shifts and integer ranges.
  function automatic logic [32:0] model(input bun_t b);
    logic [31:0] w, u, regs;
    logic e;
    int s;
    u = b.imm;
    s = int'($signed(b.imm));
    regs = (32'(b.rt) << 20) | (32'(b.rs) << 15) | (32'(b.f3) << 12) | 32'(b.op);
    w = 32'h13;
    e = 1'b1;
    case (b.fmt)
      3'd0: begin w = (32'(b.f7) << 25) | regs | (32'(b.rd) << 7); e = 1'b0; end
      3'd1: begin
        w = (fld(u, 11, 0) << 20) | (32'(b.rs) << 15) | (32'(b.f3) << 12) | (32'(b.rd) << 7) | 32'(b.op);
        e = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w = (fld(u, 11, 5) << 25) | regs | (fld(u, 4, 0) << 7);
        e = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w = (fld(u, 12, 12) << 31) | (fld(u, 10, 5) << 25) | regs | (fld(u, 4, 1) << 8) | (fld(u, 11, 11) << 7);
        e = (s < -4096) || (s > 4095) || (u % 2 != 0);
      end
      3'd4: begin
        w = ((u / 4096) * 4096) | (32'(b.rd) << 7) | 32'(b.op);
        e = (u % 4096) != 0;
      end
      3'd5: begin
        w = (fld(u, 20, 20) << 31) | (fld(u, 10, 1) << 21) | (fld(u, 11, 11) << 20) |
            (fld(u, 19, 12) << 12) | (32'(b.rd) << 7) | 32'(b.op);
        e = (s < -1048576) || (s > 1048575) || (u % 2 != 0);
      end
      default: begin w = 32'h13; e = 1'b1; end
    endcase
    return {e & CHK, w};
  endfunction

  function automatic bun_t rand_bun();
    bun_t b;
    logic [31:0] edges [14];
    edges = '{32'h7FF, 32'h800, 32'hFFFFF800, 32'hFFFFF7FF, 32'hFFF, 32'h1000,
              32'hFFFFF000, 32'hFFFFEFFF, 32'hFFFFF, 32'h100000, 32'hFFF00000,
              32'hFFEFFFFE, 32'h12345000, 32'h12345001};
    b.fmt = 3'($urandom_range(0, 7));
    b.op  = 7'($urandom);
    b.f3  = 3'($urandom);
    b.f7  = 7'($urandom);
    b.rs  = 5'($urandom);
    b.rt  = 5'($urandom);
    b.rd  = 5'($urandom);
    case ($urandom_range(0, 3))
      0: b.imm = $urandom;
      1: b.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: b.imm = edges[$urandom_range(0, 13)];
      default: b.imm = $urandom & 32'hFFFF_F000;
    endcase
    return b;
  endfunction

  // driver
  task automatic drive(input bun_t b, input logic v);
    fmtI = b.fmt; opI = b.op; funct3I = b.f3; funct7I = b.f7;
    rsI = b.rs; rtI = b.rt; rdI = b.rd; immI = b.imm;
    in_valid = v;
  endtask

  function automatic bun_t cur_bun();
    bun_t b;
    b.fmt = fmtI; b.op = opI; b.f3 = funct3I; b.f7 = funct7I;
    b.rs = rsI; b.rt = rtI; b.rd = rdI; b.imm = immI;
    return b;
  endfunction

  // One clock: record handshakes for the coming edge, scoreboard drains, then advance.
  task automatic cycle();
    logic acc, drn;
    logic [32:0] m;
    #2;
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (drn) begin
      model_emit++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected: got word %h with nothing outstanding", instnO);
      end else begin
        m = exp_q.pop_front();
        check("sb_word", instnO, m[31:0]);
        check("sb_err", 32'(errO), 32'(m[32]));
      end
    end
    if (acc) exp_q.push_back(model(cur_bun()));
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    exp_q.delete();
    model_emit = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      cycle();
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_emit"}, 32'(emit_count), 32'(model_emit[15:0]));
  endtask

  vec_t tbl [9];

  initial begin
    bun_t z, b;
    bun_t bp [4];
    int idx, gaps, n, acc_n;
    logic held;
    logic [31:0] hold_w;

    z = '{default: '0};
    drive(z, 1'b0);
    out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_instn", instnO, 32'd0);
    check("rst_err", 32'(errO), 32'd0);
    check("rst_emit", 32'(emit_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // {fmt, op, f3, f7, rs, rt, rd, imm}, expected word, expected err when checking
    tbl[0] = '{'{3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0}, 32'h002081B3, 1'b0};
    tbl[1] = '{'{3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'hFFFFFFFF}, 32'hFFF00293, 1'b0};
    tbl[2] = '{'{3'd3, 7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC}, 32'hFE208EE3, 1'b0};
    tbl[3] = '{'{3'd5, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h8}, 32'h008000EF, 1'b0};
    tbl[4] = '{'{3'd7, 7'h33, 3'd5, 7'h20, 5'd7, 5'd8, 5'd9, 32'h123}, 32'h00000013, 1'b1};
    tbl[5] = '{'{3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h800}, 32'h80000013, 1'b1};
    tbl[6] = '{'{3'd4, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h12345001}, 32'h12345037, 1'b1};
    tbl[7] = '{'{3'd2, 7'h23, 3'd2, 7'd0, 5'd2, 5'd1, 5'd0, 32'hFFFFFFF8}, 32'hFE112C23, 1'b0};
    tbl[8] = '{'{3'd4, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h12345000}, 32'h123452B7, 1'b0};

    foreach (tbl[i]) begin
      drive(tbl[i].b, 1'b1);
      out_ready = 1'b1;
      cycle();
      check("tbl_accept", 32'(last_acc), 32'd1);
      in_valid = 1'b0;
      cycle();
      check("tbl_latency_valid", 32'(out_valid), 32'd1);
      check("tbl_word", instnO, tbl[i].exp_w);
      check("tbl_err", 32'(errO), 32'(tbl[i].exp_err_chk & CHK));
      cycle();
      check("tbl_empty_after", 32'(out_valid), 32'd0);
    end

    // backpressure: four back-to-back offers against a stalled consumer
    do_reset();
    foreach (bp[i]) bp[i] = rand_bun();
    out_ready = 1'b0;
    idx = 0;
    held = 1'b0;
    hold_w = '0;
    for (int c = 0; c < 5; c++) begin
      drive(bp[idx], 1'b1);
      cycle();
      if (last_acc) idx++;
      if (out_valid) begin
        if (!held) begin hold_w = instnO; held = 1'b1; end
        else check("bp_stable", instnO, hold_w);
      end
    end
    check("bp_accepted", 32'(idx), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    gaps = 0;
    n = 0;
    while (model_emit < 4 && n < 20) begin
      if (model_emit > 0 && !out_valid) gaps++;
      if (idx < 4) drive(bp[idx], 1'b1);
      else in_valid = 1'b0;
      cycle();
      if (last_acc) idx++;
      n++;
    end
    check("bp_gaps", 32'(gaps), 32'd0);
    check("bp_emitted", 32'(model_emit), 32'd4);
    check("bp_emit_count", 32'(emit_count), 32'd4);
    drain("bp");

    // randomized traffic with random backpressure
    do_reset();
    b = rand_bun();
    in_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!in_valid || last_acc) b = rand_bun();
      drive(b, ($urandom_range(0, 3) != 0));
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drain("rand");

    // reset in the middle of a stream
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive(rand_bun(), 1'b1);
      cycle();
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_emit", 32'(emit_count), 32'd0);
    check("mid_rst_instn", instnO, 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    model_emit = 0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(tbl[7].b, 1'b1);
    cycle();
    drain("post_rst");
    check("post_rst_emit", 32'(emit_count), 32'd1);

    // emit_count wrap: 65537 words from a fresh reset
    do_reset();
    out_ready = 1'b1;
    acc_n = 0;
    n = 0;
    while (acc_n < 65537 && n < 70000) begin
      drive(rand_bun(), 1'b1);
      cycle();
      if (last_acc) acc_n++;
      n++;
    end
    check("wrap_accepted", 32'(acc_n), 32'd65537);
    drain("wrap");
    check("wrap_emit_count", 32'(emit_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
